// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier controller.
package mult_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HALT  = 3'd4
  } mc_state_t;
endpackage

// File: rtl/multiplier_control_rise_detect.sv
// Registers a level and flags its rising edge; reset value 1 masks a level
// already high when reset is released.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b1;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/multiplier_control.sv
// Sequencer for a WIDTH-iteration signed shift-add multiplier (X:A:B datapath).
module multiplier_control
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_XA,
  output logic Ld_B,
  output logic Ld_XA,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mc_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start;

  rise_detect u_rise (
    .clk  (Clk),
    .rst_n(Reset_n),
    .d    (Run),
    .rise (start)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Outputs are gated by Reset_n so they drop the instant reset asserts,
  // even while ClearA_LoadB is high in IDLE.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    if (Reset_n) begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (start) begin
            state_n = CLEAR;
          end else if (ClearA_LoadB) begin
            Ld_B   = 1'b1;
            Clr_XA = 1'b1;
          end
        end
        CLEAR: begin
          Busy    = 1'b1;
          Clr_XA  = 1'b1;
          cnt_n   = '0;
          state_n = ADD;
        end
        ADD: begin
          // The final partial product carries the sign bit: subtract it.
          Busy  = 1'b1;
          Ld_XA = M;
          if (cnt == LAST) Sub = M;
          else             Add = M;
          state_n = SHIFT;
        end
        SHIFT: begin
          Busy     = 1'b1;
          Shift_En = 1'b1;
          if (cnt == LAST) begin
            state_n = HALT;
          end else begin
            cnt_n   = cnt + CW'(1);
            state_n = ADD;
          end
        end
        HALT: begin
          Done = 1'b1;
          if (!Run) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench: controller driving a behavioural X:A:B register unit.
module tb_multiplier_control;
  import mult_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n, Run, ClearA_LoadB, M;
  logic Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  multiplier_control #(.WIDTH(8)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Run         (Run),
    .ClearA_LoadB(ClearA_LoadB),
    .M           (M),
    .Clr_XA      (Clr_XA),
    .Ld_B        (Ld_B),
    .Ld_XA       (Ld_XA),
    .Add         (Add),
    .Sub         (Sub),
    .Shift_En    (Shift_En),
    .Busy        (Busy),
    .Done        (Done)
  );

  // register unit: X (sign extension), A accumulator, B multiplier
  logic       x;
  logic [7:0] a, b, sw;
  logic [8:0] sum;
  logic       m_ovr, m_val;

  assign M = m_ovr ? m_val : b[0];

  always_comb begin
    sum = {a[7], a} + {sw[7], sw};
    if (Sub) sum = {a[7], a} - {sw[7], sw};
  end

  always_ff @(posedge Clk) begin
    if (Ld_B) b <= sw;
    if (Clr_XA) begin
      x <= 1'b0;
      a <= 8'h00;
    end else if (Ld_XA) begin
      {x, a} <= sum;
    end else if (Shift_En) begin
      a <= {x, a[7:1]};
      b <= {a[0], b[7:1]};
    end
  end

  logic [7:0] outs;
  assign outs = {Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Busy, Done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (Done !== 1'b1 && k < 60) begin
      @(negedge Clk);
      k++;
    end
    chk(tag, 32'(Done), 32'd1);
  endtask

  task automatic run_prod(input string tag, input logic [7:0] a_op, input logic [7:0] b_op,
                          input logic [15:0] exp);
    @(negedge Clk);
    sw = b_op;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    sw  = a_op;
    Run = 1'b1;
    wait_done({tag, "_done"});
    chk({tag, "_prod"}, 32'({a, b}), 32'(exp));
    Run = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    int n_add, n_sub, n_sh, sub_c, done_c, hit;
    Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b1;
    m_ovr = 1'b0; m_val = 1'b0; sw = 8'h00;
    #1;
    chk("rst_outs", 32'(outs), 32'h00);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    // IDLE load request: Ld_B and Clr_XA only
    chk("idle_load", 32'(outs), 32'b1100_0000);
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    chk("idle_quiet", 32'(outs), 32'h00);

    // cycle-accurate sequence with M forced high
    m_ovr = 1'b1; m_val = 1'b1;
    Run = 1'b1;
    n_add = 0; n_sub = 0; n_sh = 0; sub_c = 0; done_c = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge Clk);
      if (c == 1) chk("clr_c1", 32'(outs), 32'b1000_0010);
      if (Add) n_add++;
      if (Sub) begin n_sub++; sub_c = c; end
      if (Shift_En) n_sh++;
      if (Add && Sub) chk("add_sub_excl", 32'd1, 32'd0);
      if (Done && done_c == 0) done_c = c;
    end
    chk("n_add", 32'(n_add), 32'd7);
    chk("n_sub", 32'(n_sub), 32'd1);
    chk("sub_cycle", 32'(sub_c), 32'd16);
    chk("n_shift", 32'(n_sh), 32'd8);
    chk("done_cycle", 32'(done_c), 32'd18);
    chk("halt_outs", 32'(outs), 32'b0000_0001);
    @(negedge Clk);
    chk("done_hold", 32'(Done), 32'd1);
    Run = 1'b0;
    @(negedge Clk);
    chk("halt_exit", 32'(outs), 32'h00);

    // M=0 iteration: no datapath strobe in ADD
    m_val = 1'b0;
    Run = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("add_m0", 32'(outs), 32'b0000_0010);
    wait_done("m0_done");
    Run = 1'b0;
    @(negedge Clk);
    m_ovr = 1'b0;

    // signed products through the register unit
    run_prod("p7xm3", 8'h07, 8'hFD, 16'hFFEB);
    run_prod("pm128sq", 8'h80, 8'h80, 16'h4000);

    // Run glitch mid-op and Run held through HALT
    Run = 1'b1; n_sh = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clk);
      if (Shift_En) n_sh++;
      if (c == 5) Run = 1'b0;
      if (c == 6) Run = 1'b1;
      if (c == 7) ClearA_LoadB = 1'b1;
      if (c == 8) ClearA_LoadB = 1'b0;
    end
    chk("glitch_shifts", 32'(n_sh), 32'd8);
    chk("glitch_hold", 32'(outs), 32'b0000_0001);
    Run = 1'b0;
    @(negedge Clk);
    chk("glitch_exit", 32'(outs), 32'h00);

    // reset mid-operation with Run held high
    Run = 1'b1;
    for (int c = 1; c <= 9; c++) @(negedge Clk);
    chk("pre_rst_busy", 32'(Busy), 32'd1);
    Reset_n = 1'b0; ClearA_LoadB = 1'b1;
    #1;
    chk("mid_rst_outs", 32'(outs), 32'h00);
    @(negedge Clk);
    Reset_n = 1'b1; ClearA_LoadB = 1'b0;
    hit = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge Clk);
      if (Busy || Clr_XA) hit = 1;
    end
    chk("no_restart", 32'(hit), 32'd0);
    Run = 1'b0;
    @(negedge Clk);
    Run = 1'b1;
    @(negedge Clk);
    chk("restart", 32'(outs), 32'b1000_0010);
    wait_done("restart_done");
    Run = 1'b0;
    @(negedge Clk);

    // start coincident with load request
    Run = 1'b1; ClearA_LoadB = 1'b1;
    #1;
    chk("start_prio_ldb", 32'(Ld_B), 32'd0);
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    chk("start_prio_clr", 32'(outs), 32'b1000_0010);
    wait_done("prio_done");
    Run = 1'b0;
    @(negedge Clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
